// File: rtl/mips_multicycle_control.sv
// Main control FSM for the multicycle MIPS datapath: fetch/decode/execute/memory/write-back
// sequencing with mem_ready-held memory states and a wait-timeout abort.
module mips_multicycle_control #(
    parameter int WAIT_LIMIT = 15
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic       iord,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       mem_to_reg,
    output logic       reg_write,
    output logic       reg_dst,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [1:0] pc_source,
    output logic       illegal_op,
    output logic       mem_timeout,
    output logic [3:0] state_out
);

    typedef enum logic [3:0] {
        FETCH     = 4'd0,
        DECODE    = 4'd1,
        MEM_ADDR  = 4'd2,
        MEM_READ  = 4'd3,
        MEM_WB    = 4'd4,
        MEM_WRITE = 4'd5,
        EXECUTE   = 4'd6,
        R_WB      = 4'd7,
        BRANCH    = 4'd8,
        JUMP      = 4'd9,
        ADDI_EX   = 4'd10,
        ADDI_WB   = 4'd11
    } state_t;

    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_ADDI = 6'b001000;

    state_t     state;
    state_t     next_state;
    logic [7:0] cnt;
    logic [7:0] cnt_next;
    logic       waiting;
    logic       timeout;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= FETCH;
            cnt   <= 8'd0;
        end else begin
            state <= next_state;
            cnt   <= cnt_next;
        end
    end

    assign state_out = reset ? 4'd0 : state;

    always_comb begin
        next_state    = FETCH;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        iord          = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        mem_to_reg    = 1'b0;
        reg_write     = 1'b0;
        reg_dst       = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'b00;
        alu_op        = 2'b00;
        pc_source     = 2'b00;
        illegal_op    = 1'b0;
        mem_timeout   = 1'b0;

        // The counter only runs while a memory state is stalled; any other cycle leaves it at zero,
        // so entering a memory state always starts from a cleared count.
        waiting  = ((state == FETCH) || (state == MEM_READ) || (state == MEM_WRITE)) && !mem_ready;
        timeout  = waiting && (cnt == 8'(WAIT_LIMIT));
        cnt_next = (waiting && !timeout) ? cnt + 8'd1 : 8'd0;

        if (!reset) begin
            mem_timeout = timeout;
            case (state)
                FETCH: begin
                    mem_read   = 1'b1;
                    alu_src_b  = 2'b01;
                    ir_write   = mem_ready;
                    pc_write   = mem_ready;
                    next_state = mem_ready ? DECODE : FETCH;
                end
                DECODE: begin
                    alu_src_b = 2'b11;
                    case (opcode)
                        OP_LW, OP_SW: next_state = MEM_ADDR;
                        OP_R:         next_state = EXECUTE;
                        OP_BEQ:       next_state = BRANCH;
                        OP_J:         next_state = JUMP;
                        OP_ADDI:      next_state = ADDI_EX;
                        default: begin
                            illegal_op = 1'b1;
                            next_state = FETCH;
                        end
                    endcase
                end
                MEM_ADDR: begin
                    alu_src_a  = 1'b1;
                    alu_src_b  = 2'b10;
                    next_state = (opcode == OP_SW) ? MEM_WRITE : MEM_READ;
                end
                MEM_READ: begin
                    mem_read = 1'b1;
                    iord     = 1'b1;
                    if (mem_ready)    next_state = MEM_WB;
                    else if (timeout) next_state = FETCH;
                    else              next_state = MEM_READ;
                end
                MEM_WB: begin
                    reg_write  = 1'b1;
                    mem_to_reg = 1'b1;
                end
                MEM_WRITE: begin
                    mem_write = 1'b1;
                    iord      = 1'b1;
                    if (mem_ready || timeout) next_state = FETCH;
                    else                      next_state = MEM_WRITE;
                end
                EXECUTE: begin
                    alu_src_a  = 1'b1;
                    alu_op     = 2'b10;
                    next_state = R_WB;
                end
                R_WB: begin
                    reg_write = 1'b1;
                    reg_dst   = 1'b1;
                end
                BRANCH: begin
                    alu_src_a     = 1'b1;
                    alu_op        = 2'b01;
                    pc_write_cond = 1'b1;
                    pc_source     = 2'b01;
                end
                JUMP: begin
                    pc_write  = 1'b1;
                    pc_source = 2'b10;
                end
                ADDI_EX: begin
                    alu_src_a  = 1'b1;
                    alu_src_b  = 2'b10;
                    next_state = ADDI_WB;
                end
                ADDI_WB: begin
                    reg_write = 1'b1;
                end
                default: next_state = FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Bench for mips_multicycle_control: builds the expected per-cycle trace of each instruction
// from its opcode and chosen memory wait counts, then drives it and checks every cycle.
module tb_mips_multicycle_control;

    localparam int WL = 4;

    localparam logic [5:0] LW   = 6'b100011;
    localparam logic [5:0] SW   = 6'b101011;
    localparam logic [5:0] RT   = 6'b000000;
    localparam logic [5:0] BEQ  = 6'b000100;
    localparam logic [5:0] JMP  = 6'b000010;
    localparam logic [5:0] ADDI = 6'b001000;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] opcode;
    logic       mem_ready;
    logic       pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write;
    logic       mem_to_reg, reg_write, reg_dst, alu_src_a;
    logic [1:0] alu_src_b, alu_op, pc_source;
    logic       illegal_op, mem_timeout;
    logic [3:0] state_out;
    logic [17:0] outs_vec;

    int total = 0;
    int bad = 0;

    // {reset, opcode, mem_ready, state, outputs}
    logic [29:0] exp_q[$];

    mips_multicycle_control #(.WAIT_LIMIT(WL)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
        .pc_write(pc_write), .pc_write_cond(pc_write_cond), .iord(iord),
        .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
        .mem_to_reg(mem_to_reg), .reg_write(reg_write), .reg_dst(reg_dst),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
        .pc_source(pc_source), .illegal_op(illegal_op), .mem_timeout(mem_timeout),
        .state_out(state_out)
    );

    always #5 clk = ~clk;

    assign outs_vec = {pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write,
                       mem_to_reg, reg_write, reg_dst, alu_src_a, alu_src_b, alu_op,
                       pc_source, illegal_op, mem_timeout};

    // Expected control word of each step, straight from the step descriptions.
    function automatic logic [17:0] spec_outs(int st, logic rdy, logic ill, logic tmo);
        logic pw, pwc, ad, mr, mw, irw, m2r, rw, rd, asa;
        logic [1:0] asb, aop, ps;
        {pw, pwc, ad, mr, mw, irw, m2r, rw, rd, asa} = 10'd0;
        asb = 2'b00; aop = 2'b00; ps = 2'b00;
        case (st)
            0:  begin mr = 1; asb = 2'b01; pw = rdy; irw = rdy; end
            1:  asb = 2'b11;
            2:  begin asa = 1; asb = 2'b10; end
            3:  begin mr = 1; ad = 1; end
            4:  begin rw = 1; m2r = 1; end
            5:  begin mw = 1; ad = 1; end
            6:  begin asa = 1; aop = 2'b10; end
            7:  begin rw = 1; rd = 1; end
            8:  begin asa = 1; aop = 2'b01; pwc = 1; ps = 2'b01; end
            9:  begin pw = 1; ps = 2'b10; end
            10: begin asa = 1; asb = 2'b10; end
            11: rw = 1;
            default: ;
        endcase
        return {pw, pwc, ad, mr, mw, irw, m2r, rw, rd, asa, asb, aop, ps, ill, tmo};
    endfunction

    task automatic push(input logic [5:0] op, input int st, input logic rdy,
                        input logic ill, input logic tmo);
        exp_q.push_back({1'b0, op, rdy, 4'(st), spec_outs(st, rdy, ill, tmo)});
    endtask

    // A memory step stalled for `waits` cycles; waits >= WL ends in the abort cycle.
    task automatic mem_phase(input logic [5:0] op, input int st, input int waits, output bit to);
        int n;
        n = (waits < WL) ? waits : WL;
        for (int i = 0; i < n; i++) push(op, st, 1'b0, 1'b0, 1'b0);
        if (waits >= WL) begin
            push(op, st, 1'b0, 1'b0, 1'b1);
            to = 1'b1;
        end else begin
            push(op, st, 1'b1, 1'b0, 1'b0);
            to = 1'b0;
        end
    endtask

    task automatic build(input logic [5:0] op, input int fw, input int fw2, input int mw);
        bit to;
        logic sup;
        mem_phase(op, 0, fw, to);
        if (to) mem_phase(op, 0, fw2, to);
        if (to) return;
        sup = (op == LW) || (op == SW) || (op == RT) || (op == BEQ) || (op == JMP) || (op == ADDI);
        push(op, 1, 1'($urandom_range(0, 1)), !sup, 1'b0);
        if (op == LW) begin
            push(op, 2, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
            mem_phase(op, 3, mw, to);
            if (!to) push(op, 4, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
        end else if (op == SW) begin
            push(op, 2, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
            mem_phase(op, 5, mw, to);
        end else if (op == RT) begin
            push(op, 6, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
            push(op, 7, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
        end else if (op == BEQ) begin
            push(op, 8, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
        end else if (op == JMP) begin
            push(op, 9, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
        end else if (op == ADDI) begin
            push(op, 10, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
            push(op, 11, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
        end
    endtask

    task automatic check_cycle(input logic rst, input logic [5:0] op, input logic rdy,
                               input logic [3:0] st, input logic [17:0] outs);
        @(negedge clk);
        reset = rst;
        opcode = op;
        mem_ready = rdy;
        #1;
        total++;
        assert (state_out === st) else begin
            bad++;
            $error("FAIL state: got %0d expected %0d (op=%b rdy=%b rst=%b)", state_out, st, op, rdy, rst);
        end
        total++;
        assert (outs_vec === outs) else begin
            bad++;
            $error("FAIL outputs: got %b expected %b (state=%0d op=%b rdy=%b rst=%b)",
                   outs_vec, outs, st, op, rdy, rst);
        end
        total++;
        assert (!(mem_read && mem_write) && !(reg_write && mem_write)) else begin
            bad++;
            $error("FAIL exclusive: got mr=%b mw=%b rw=%b expected no overlap", mem_read, mem_write, reg_write);
        end
    endtask

    task automatic drain();
        logic [29:0] e;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check_cycle(e[29], e[28:23], e[22], e[21:18], e[17:0]);
        end
    endtask

    initial begin
        logic [5:0] op;
        logic [5:0] ops[6];
        ops[0] = LW; ops[1] = SW; ops[2] = RT; ops[3] = BEQ; ops[4] = JMP; ops[5] = ADDI;
        reset = 1'b1;
        opcode = 6'd0;
        mem_ready = 1'b0;

        check_cycle(1'b1, 6'd0, 1'b1, 4'd0, 18'd0);
        check_cycle(1'b1, 6'd0, 1'b1, 4'd0, 18'd0);

        build(LW, 0, 0, 0);        drain();
        build(RT, 0, 0, 0);        drain();
        build(SW, 0, 0, 3);        drain();
        build(6'h3f, 0, 0, 0);     drain();
        build(ADDI, WL, WL - 1, 0); drain();
        build(LW, 0, 0, WL);       drain();
        build(SW, 1, 0, WL + 1);   drain();
        build(BEQ, 2, 0, 0);       drain();
        build(JMP, 0, 0, 0);       drain();

        // Reset in the middle of a stalled load.
        push(LW, 0, 1'b1, 1'b0, 1'b0);
        push(LW, 1, 1'b0, 1'b0, 1'b0);
        push(LW, 2, 1'b1, 1'b0, 1'b0);
        push(LW, 3, 1'b0, 1'b0, 1'b0);
        push(LW, 3, 1'b0, 1'b0, 1'b0);
        drain();
        check_cycle(1'b1, LW, 1'b0, 4'd0, 18'd0);
        check_cycle(1'b1, LW, 1'b1, 4'd0, 18'd0);
        check_cycle(1'b0, LW, 1'b0, 4'd0, spec_outs(0, 1'b0, 1'b0, 1'b0));
        build(LW, 0, 0, 0);        drain();

        for (int n = 0; n < 60; n++) begin
            if ($urandom_range(0, 6) == 0) begin
                op = 6'($urandom_range(0, 63));
                while (op == LW || op == SW || op == RT || op == BEQ || op == JMP || op == ADDI)
                    op = 6'($urandom_range(0, 63));
            end else begin
                op = ops[$urandom_range(0, 5)];
            end
            build(op, $urandom_range(0, WL + 1), $urandom_range(0, WL - 1), $urandom_range(0, WL + 1));
            drain();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
